// File: rtl/mem_if_pkg.sv
// mem_if_pkg: shared FSM state encoding and line geometry for the L1 line-fetch block
package mem_if_pkg;
  typedef enum logic [2:0] {S_IDLE, S_REQ, S_ADDR, S_BASE, S_COUNT, S_CLOSE, S_SDATA} state_t;
  localparam int LINE_WORDS = 8;
  localparam logic [3:0] ACK_IDLE = 4'hF;
endpackage

// File: rtl/line_fill_buffer.sv
// line_fill_buffer: 8x32 line assembly buffer with single-cycle run write of words lo..lo+cnt-1
// Ports: i_clk/i_rst_n clock and async active-low reset; i_clr clears all words;
//        i_we with i_lo/i_cnt/i_data writes one run; o_line is the packed buffer (word i at [32i+31:32i]).
module line_fill_buffer
  import mem_if_pkg::*;
(
  input  logic                       i_clk,
  input  logic                       i_rst_n,
  input  logic                       i_clr,
  input  logic                       i_we,
  input  logic [3:0]                 i_lo,
  input  logic [3:0]                 i_cnt,
  input  logic [31:0]                i_data,
  output logic [32*LINE_WORDS-1:0]   o_line
);
  logic [31:0] r_mem [LINE_WORDS];
  always_ff @(posedge i_clk or negedge i_rst_n)
    if (!i_rst_n)
      for (int k = 0; k < LINE_WORDS; k++) r_mem[k] <= '0;
    else
      for (int k = 0; k < LINE_WORDS; k++)
        if (i_clr) r_mem[k] <= '0;
        else if (i_we && 4'(k) >= i_lo && 4'(k) < i_lo + i_cnt) r_mem[k] <= i_data;
  for (genvar g = 0; g < LINE_WORDS; g++) begin : g_out
    assign o_line[32*g +: 32] = r_mem[g];
  end
endmodule

// File: rtl/l1_line_fetch.sv
// l1_line_fetch: L1-side controller for run-length line fills and single-word stores to memory
// Ports: i_req_load/i_req_store/i_req_addr/i_req_wdata CPU request; o_busy/o_done/o_err/o_line_data CPU status;
//        o_data_l1, o_valid, o_load, o_store, o_ack_*_l1, o_reset_ack_l1 drive memory;
//        i_data_mem, i_ready, i_ack_*_mem, i_reset_ack_mem come back from memory.
// Optional: define L1_TIMEOUT_EN to abort after TIMEOUT_CYCLES cycles in any non-IDLE state.
module l1_line_fetch
  import mem_if_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic                     i_clk,
  input  logic                     i_rst_n,
  input  logic                     i_req_load,
  input  logic                     i_req_store,
  input  logic [31:0]              i_req_addr,
  input  logic [31:0]              i_req_wdata,
  output logic                     o_busy,
  output logic                     o_done,
  output logic                     o_err,
  output logic [32*LINE_WORDS-1:0] o_line_data,
  output logic [31:0]              o_data_l1,
  input  logic [31:0]              i_data_mem,
  output logic                     o_valid,
  input  logic                     i_ready,
  output logic                     o_load,
  output logic                     o_store,
  output logic [3:0]               o_ack_data_l1,
  input  logic [3:0]               i_ack_data_mem,
  output logic                     o_ack_addr_l1,
  input  logic                     i_ack_addr_mem,
  output logic                     o_ack_count_l1,
  input  logic                     i_ack_count_mem,
  output logic                     o_reset_ack_l1,
  input  logic                     i_reset_ack_mem
);
  state_t                   r_state;
  logic [31:0]              r_addr, r_wdata, r_base;
  logic [3:0]               r_n;
  logic                     r_mis;
  logic [32*LINE_WORDS-1:0] w_fill;
  logic [3:0]               w_end;
  logic [7:0]               w_age;
  logic                     w_c_ok, w_tmo, w_abort, w_we, w_clr;
`ifdef L1_TIMEOUT_EN
  localparam bit TMO_EN = 1'b1;
  state_t     r_state_d;
  logic [7:0] r_age;
  // age restarts whenever the state register differs from last cycle's value
  assign w_age = (r_state != r_state_d) ? 8'd0 : r_age;
  always_ff @(posedge i_clk or negedge i_rst_n)
    if (!i_rst_n) begin
      r_state_d <= S_IDLE;
      r_age     <= '0;
    end else begin
      r_state_d <= r_state;
      r_age     <= w_age + 8'd1;
    end
`else
  localparam bit TMO_EN = 1'b0;
  assign w_age = '0;
`endif
  assign w_tmo   = TMO_EN && r_state != S_IDLE && 9'(w_age) + 9'd1 == 9'(TIMEOUT_CYCLES);
  // run count is judged on all 32 bits so junk in the upper bits cannot alias to a legal count
  assign w_c_ok  = i_data_mem != 32'd0 && i_data_mem <= 32'(LINE_WORDS) - 32'(r_n);
  assign w_end   = r_n + i_data_mem[3:0];
  assign w_abort = w_tmo || (r_state == S_BASE && r_mis) ||
                   (r_state == S_COUNT && i_ack_count_mem && !w_c_ok);
  assign w_we    = r_state == S_COUNT && i_ack_count_mem && !w_abort;
  assign w_clr   = r_state == S_IDLE && (i_req_load || i_req_store);
  line_fill_buffer u_fill (
    .i_clk  (i_clk),
    .i_rst_n(i_rst_n),
    .i_clr  (w_clr),
    .i_we   (w_we),
    .i_lo   (r_n),
    .i_cnt  (i_data_mem[3:0]),
    .i_data (r_base),
    .o_line (w_fill)
  );
  always_ff @(posedge i_clk or negedge i_rst_n)
    if (!i_rst_n) begin
      r_state        <= S_IDLE;
      r_addr         <= '0;
      r_wdata        <= '0;
      r_base         <= '0;
      r_n            <= '0;
      r_mis          <= 1'b0;
      o_busy         <= 1'b0;
      o_done         <= 1'b0;
      o_err          <= 1'b0;
      o_line_data    <= '0;
      o_data_l1      <= '0;
      o_valid        <= 1'b0;
      o_load         <= 1'b0;
      o_store        <= 1'b0;
      o_ack_data_l1  <= ACK_IDLE;
      o_ack_addr_l1  <= 1'b0;
      o_ack_count_l1 <= 1'b0;
      o_reset_ack_l1 <= 1'b0;
    end else begin
      o_done         <= 1'b0;
      o_err          <= 1'b0;
      o_reset_ack_l1 <= 1'b0;
      if (w_abort) begin
        r_state        <= S_IDLE;
        r_mis          <= 1'b0;
        o_err          <= 1'b1;
        o_done         <= 1'b1;
        o_reset_ack_l1 <= 1'b1;
        o_busy         <= 1'b0;
        o_valid        <= 1'b0;
        o_load         <= 1'b0;
        o_store        <= 1'b0;
        o_data_l1      <= '0;
        o_ack_data_l1  <= ACK_IDLE;
        o_ack_addr_l1  <= 1'b0;
        o_ack_count_l1 <= 1'b0;
      end else begin
        case (r_state)
          S_IDLE:
            if (i_req_load || i_req_store) begin
              r_addr  <= i_req_addr;
              r_wdata <= i_req_wdata;
              r_n     <= '0;
              r_mis   <= 1'b0;
              o_valid <= 1'b1;
              o_load  <= i_req_load;
              o_store <= !i_req_load;
              o_busy  <= 1'b1;
              r_state <= S_REQ;
            end
          S_REQ:
            if (i_ready) begin
              o_data_l1     <= r_addr;
              o_ack_addr_l1 <= 1'b1;
              r_state       <= S_ADDR;
            end
          S_ADDR:
            if (i_ack_addr_mem) begin
              o_ack_addr_l1 <= 1'b0;
              if (o_load) r_state <= S_BASE;
              else begin
                o_data_l1     <= r_wdata;
                o_ack_data_l1 <= 4'd0;
                r_state       <= S_SDATA;
              end
            end
          S_BASE:
            if (!i_ack_count_mem && i_ack_data_mem == r_n) begin
              r_base         <= i_data_mem;
              o_ack_data_l1  <= r_n;
              o_ack_count_l1 <= 1'b0;
              r_state        <= S_COUNT;
            end else if (!i_ack_count_mem && i_ack_data_mem != ACK_IDLE) r_mis <= 1'b1;
          S_COUNT:
            if (i_ack_count_mem) begin
              o_ack_data_l1  <= w_end - 4'd1;
              o_ack_count_l1 <= 1'b1;
              r_n            <= w_end;
              r_state        <= (w_end == 4'(LINE_WORDS)) ? S_CLOSE : S_BASE;
            end
          S_CLOSE:
            if (i_reset_ack_mem) begin
              o_line_data    <= w_fill;
              o_reset_ack_l1 <= 1'b1;
              o_done         <= 1'b1;
              o_valid        <= 1'b0;
              o_load         <= 1'b0;
              o_busy         <= 1'b0;
              o_ack_data_l1  <= ACK_IDLE;
              o_ack_count_l1 <= 1'b0;
              r_state        <= S_IDLE;
            end
          S_SDATA:
            if (!i_ready && i_ack_data_mem == 4'd0) begin
              o_reset_ack_l1 <= 1'b1;
              o_done         <= 1'b1;
              o_valid        <= 1'b0;
              o_store        <= 1'b0;
              o_busy         <= 1'b0;
              o_ack_data_l1  <= ACK_IDLE;
              r_state        <= S_IDLE;
            end
          default: r_state <= S_IDLE;
        endcase
      end
    end
endmodule

// File: doc/l1_line_fetch.md
L1_LINE_FETCH -- requirements
Module: l1_line_fetch

Interface
REQ-001 SHALL have parameter: TIMEOUT_CYCLES, default 255, maximum cycles in one non-IDLE state before abort (only used with L1_TIMEOUT_EN).
REQ-002 SHALL have port: CLK  in  1  clock, all state on rising edge.
REQ-003 SHALL have port: RST_N  in  1  reset; one clock, asynchronous, active-low.
REQ-004 SHALL have port: REQ_LOAD  in  1  CPU-side line-fill request.
REQ-005 SHALL have port: REQ_STORE  in  1  CPU-side single-word store request.
REQ-006 SHALL have port: REQ_ADDR  in  32  word address.
REQ-007 SHALL have port: REQ_WDATA  in  32  store data.
REQ-008 SHALL have port: BUSY  out  1  transaction in progress.
REQ-009 SHALL have port: DONE  out  1  one-cycle completion pulse.
REQ-010 SHALL have port: ERR  out  1  one-cycle pulse, coincident with DONE, on abort.
REQ-011 SHALL have port: LINE_DATA  out  256  filled line; word i at bits [32i+31:32i].
REQ-012 SHALL have port: DATA_L1  out  32  address or store data to memory.
REQ-013 SHALL have port: DATA_MEM  in  32  base word or run count from memory.
REQ-014 SHALL have port: VALID  out  1  request active.
REQ-015 SHALL have port: READY  in  1  memory engaged.
REQ-016 SHALL have port: LOAD  out  1  load transaction.
REQ-017 SHALL have port: STORE  out  1  store transaction.
REQ-018 SHALL have port: ACK_DATA_L1  out  4  acknowledged word index; 4'hF = idle.
REQ-019 SHALL have port: ACK_DATA_MEM  in  4  memory word index; 4'hF = idle.
REQ-020 SHALL have port: ACK_ADDR_L1  out  1  address valid on DATA_L1.
REQ-021 SHALL have port: ACK_ADDR_MEM  in  1  address accepted.
REQ-022 SHALL have port: ACK_COUNT_L1  out  1  run count acknowledged.
REQ-023 SHALL have port: ACK_COUNT_MEM  in  1  DATA_MEM holds run count (else base word).
REQ-024 SHALL have port: RESET_ACK_L1  out  1  one-cycle close pulse.
REQ-025 SHALL have port: RESET_ACK_MEM  in  1  memory closed load.

Function
REQ-026 SHALL use states IDLE, REQ, ADDR, BASE, COUNT, CLOSE, SDATA; all outputs registered; requests while BUSY ignored; REQ_LOAD has priority over simultaneous REQ_STORE.
REQ-027 SHALL, in IDLE on a request: latch address/data, clear next-index n=0, assert VALID plus LOAD or STORE, set BUSY, then go to REQ.
REQ-028 SHALL, in REQ on READY=1: drive DATA_L1=address, ACK_ADDR_L1=1, then go to ADDR.
REQ-029 SHALL, in ADDR on ACK_ADDR_MEM=1: clear ACK_ADDR_L1; a load goes to BASE; a store drives DATA_L1=data, ACK_DATA_L1=0, then goes to SDATA.
REQ-030 SHALL, in BASE on ACK_COUNT_MEM=0 and ACK_DATA_MEM==n: capture base=DATA_MEM, drive ACK_DATA_L1=n, ACK_COUNT_L1=0, then go to COUNT. Index mismatch in BASE is held for 1 cycle, then causes an abort.
REQ-031 SHALL, in COUNT on ACK_COUNT_MEM=1: capture c=DATA_MEM, compared at full 32 bits; legal range 1..8-n, else abort. Write base into fill words n..n+c-1 in one cycle, drive ACK_DATA_L1=n+c-1, ACK_COUNT_L1=1, set n+=c; then go to CLOSE when n==8, else to BASE.
REQ-032 SHALL, in CLOSE on RESET_ACK_MEM=1: commit fill buffer to LINE_DATA, pulse RESET_ACK_L1 and DONE, drop VALID/LOAD/BUSY, set ACK_DATA_L1=4'hF and ACK_COUNT_L1=0, then go to IDLE.
REQ-033 SHALL, in SDATA on READY=0 and ACK_DATA_MEM=0: pulse RESET_ACK_L1 and DONE, drop VALID/STORE/BUSY, set ACK_DATA_L1=4'hF, then go to IDLE.
REQ-034 SHALL, on abort: pulse ERR and DONE and RESET_ACK_L1, return all handshake outputs to idle values, go to IDLE, and leave LINE_DATA unchanged.

Reset
REQ-035 SHALL, while RST_N=0, immediately force state=IDLE, ACK_DATA_L1=4'hF, LINE_DATA=0 and every other output 0; a transfer in flight is dropped without a RESET_ACK_L1 pulse.

Configuration
REQ-036 SHALL, with L1_TIMEOUT_EN defined, run an 8-bit counter cleared on every state change and abort when it reaches TIMEOUT_CYCLES in any non-IDLE state; without L1_TIMEOUT_EN, no counter and unbounded waits.

Structure
REQ-037 SHALL place state enum, LINE_WORDS=8, ACK_IDLE=4'hF in shared package mem_if_pkg; fill buffer SHALL be sub-module line_fill_buffer (8x32, range write n..n+c-1, clear on start).

Verification
REQ-038 SHALL cover: load 0x13, base 0xA, c=8 -> all LINE_DATA words 0xA; ACK_DATA_L1 sequence 0 then 7; DONE 1 cycle.
REQ-039 SHALL cover: runs (0x10,c=3) then (0x50,c=5) -> words 0-2=0x10, words 3-7=0x50; ACK_DATA_L1 sequence 0,2,3,7.
REQ-040 SHALL cover: store 0x40/0xDEADBEEF -> DATA_L1=0x40 with ACK_ADDR_L1, then 0xDEADBEEF with ACK_DATA_L1=0; DONE; ERR=0.
REQ-041 SHALL cover: c=0 or c=9 at n=0 -> ERR+DONE same cycle; LINE_DATA keeps prior value.
REQ-042 SHALL cover: RST_N low in COUNT -> reset values at once; a following load completes normally.
REQ-043 SHALL cover: with L1_TIMEOUT_EN and READY held 0 -> ERR after 255 cycles in REQ.
